// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : result_uart_tx
// Brief    : Prints a 32-bit result as decimal ASCII + CR LF over UART 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] result,
  input  logic        result_valid,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int                BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_prev_valid;
  logic [31:0]       r_bin;
  logic [39:0]       r_bcd;
  logic [4:0]        r_step;
  logic [3:0]        r_digit_idx;
  logic [1:0]        r_phase;      // 0: digits, 1: CR, 2: LF
  logic [7:0]        r_byte;
  logic [3:0]        r_bit_cnt;
  logic [BAUD_W-1:0] r_baud;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  logic              w_trigger;
  logic              w_frame_end;
  logic [39:0]       w_adj;
  logic [3:0]        w_msd;
  logic [3:0]        w_adv_idx;
  logic [1:0]        w_adv_phase;
  logic [3:0]        w_adv_digit;
  logic [7:0]        w_adv_byte;
  logic [7:0]        w_first_byte;
  logic              w_frame_bit;

  assign w_trigger   = (r_state == S_IDLE) && result_valid && !r_prev_valid;
  assign w_frame_end = (r_state == S_SEND) && (r_baud == c_baud_last) && (r_bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_next = S_CONV;
      S_CONV:  if (r_step == 5'd31) w_next = S_LOAD;
      S_LOAD:  w_next = S_SEND;
      S_SEND:  if (w_frame_end && (r_phase == 2'd2)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Double-dabble add-3 correction and most-significant nonzero digit search
  always_comb begin
    w_adj = r_bcd;
    w_msd = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = 4'(i);
    end
  end

  assign w_first_byte = 8'h30 | {4'h0, 4'(r_bcd >> {w_msd, 2'b00})};

  always_comb begin
    w_adv_idx   = r_digit_idx;
    w_adv_phase = r_phase;
    if (r_phase == 2'd0) begin
      if (r_digit_idx == 4'd0) w_adv_phase = 2'd1;
      else                     w_adv_idx   = r_digit_idx - 4'd1;
    end else if (r_phase == 2'd1) begin
      w_adv_phase = 2'd2;
    end
    w_adv_digit = 4'(r_bcd >> {w_adv_idx, 2'b00});
    case (w_adv_phase)
      2'd0:    w_adv_byte = 8'h30 | {4'h0, w_adv_digit};
      2'd1:    w_adv_byte = 8'h0D;
      default: w_adv_byte = 8'h0A;
    endcase
  end

  always_comb begin
    case (r_bit_cnt)
      4'd0:    w_frame_bit = 1'b0;
      4'd9:    w_frame_bit = 1'b1;
      default: w_frame_bit = r_byte[3'(r_bit_cnt - 4'd1)];
    endcase
  end

  // tx/busy/done are registered, so they lag the state by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_valid <= 1'b0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_step       <= '0;
      r_digit_idx  <= '0;
      r_phase      <= '0;
      r_byte       <= '0;
      r_bit_cnt    <= '0;
      r_baud       <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_prev_valid <= result_valid;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_trigger) begin
            r_bin  <= result;
            r_bcd  <= '0;
            r_step <= '0;
            r_busy <= 1'b1;
          end
        end
        S_CONV: begin
          r_bcd  <= {w_adj[38:0], r_bin[31]};
          r_bin  <= {r_bin[30:0], 1'b0};
          r_step <= r_step + 5'd1;
        end
        S_LOAD: begin
          r_digit_idx <= w_msd;
          r_phase     <= 2'd0;
          r_byte      <= w_first_byte;
          r_bit_cnt   <= 4'd0;
          r_baud      <= '0;
        end
        S_SEND: begin
          r_tx <= w_frame_bit;
          if (r_baud == c_baud_last) begin
            r_baud <= '0;
            if (r_bit_cnt == 4'd9) begin
              // Next byte is loaded here so frames run back-to-back
              r_bit_cnt <= 4'd0;
              if (r_phase != 2'd2) begin
                r_digit_idx <= w_adv_idx;
                r_phase     <= w_adv_phase;
                r_byte      <= w_adv_byte;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DONE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_uart_tx
// Brief    : Directed checks of result_uart_tx framing, timing and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] result = '0;
  logic        result_valid = 1'b0;
  logic        tx;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic tx_log   [0:1023];
  logic busy_log [0:1023];
  logic done_log [0:1023];

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result       (result),
    .result_valid (result_valid),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trigger one transmission of val and check every frame against exp_s + CR LF.
  task automatic xmit(input logic [31:0] val, input string exp_s, input bit hold);
    int   nb;
    int   win;
    int   first_low;
    int   busy_cnt;
    int   done_at;
    int   done_cnt;
    int   base;
    logic [7:0] eb;
    logic [9:0] fr;
    nb        = exp_s.len() + 2;
    win       = 34 + nb * FRAME + 8;
    first_low = -1;
    busy_cnt  = 0;
    done_at   = -1;
    done_cnt  = 0;
    @(negedge clk);
    result       = val;
    result_valid = 1'b1;
    for (int j = 0; j < win; j++) begin
      @(negedge clk);
      tx_log[j]   = tx;
      busy_log[j] = busy;
      done_log[j] = done;
      if (j == 0 && !hold) result_valid = 1'b0;
      if (j == 5)  result = 32'd7;
      if (j == 60) result = 32'd7;
      if (tx == 1'b0 && first_low < 0) first_low = j;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
    end
    chk({exp_s, " start_latency"}, first_low, 34);
    chk({exp_s, " busy_cycles"}, busy_cnt, 34 + nb * FRAME);
    chk({exp_s, " done_at"}, done_at, 34 + nb * FRAME);
    chk({exp_s, " done_pulses"}, done_cnt, 1);
    for (int k = 0; k < nb; k++) begin
      if (k < nb - 2)       eb = exp_s[k];
      else if (k == nb - 2) eb = 8'h0D;
      else                  eb = 8'h0A;
      base = 34 + k * FRAME;
      for (int b = 0; b < 10; b++) fr[b] = tx_log[base + b * CPB + CPB / 2];
      chk($sformatf("%s frame%0d", exp_s, k), {22'd0, fr}, {22'd0, 1'b1, eb, 1'b0});
    end
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xmit(32'd233168, "233168", 1'b0);
    xmit(32'd0, "0", 1'b0);
    xmit(32'd1000, "1000", 1'b0);
    xmit(32'hFFFF_FFFF, "4294967295", 1'b0);

    // Level held high: one transmission only, then a fresh edge retriggers
    xmit(32'd42, "42", 1'b1);
    bad = 0;
    for (int j = 0; j < 4800; j++) begin
      @(negedge clk);
      if (busy || done || !tx) bad++;
    end
    chk("hold_no_retrigger", bad, 0);
    result_valid = 1'b0;
    @(negedge clk);
    xmit(32'd5, "5", 1'b0);

    // Async reset during data bit 2 of the third byte ('3' = 0x33, bit 2 = 0)
    @(negedge clk);
    result       = 32'd233168;
    result_valid = 1'b1;
    for (int j = 0; j <= 127; j++) begin
      @(negedge clk);
      if (j == 0) result_valid = 1'b0;
    end
    #1;
    chk("pre_reset_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (!tx || busy || done) bad++;
    end
    chk("post_reset_idle", bad, 0);

    xmit(32'd907, "907", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Reads the 32-bit result of a problem solver core and transmits it as decimal ASCII over a UART 8N1 line, followed by CR LF.
- Sits between a solver's `result` output and the board's UART TX pin, so results can be read on a host terminal.
- Internals: rising-edge detect on `result_valid`, 32-cycle binary-to-BCD conversion (double-dabble), digit sequencer, bit-level UART serializer.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- result  input  32  unsigned value to print; sampled only on trigger.
- result_valid  input  1  level; its rising edge starts one transmission.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high from trigger cycle until the final stop bit completes.
- done  output  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, busy=0, done=0, state IDLE.
  - Edge-detect register cleared to 0, so a `result_valid` already high at reset release triggers once.
  - Any in-flight frame is aborted immediately, with no partial stop bit.
- Trigger: in IDLE, `result_valid`=1 while the registered previous value is 0.
  - `result` is captured that cycle and `busy` goes 1 on the next edge.
  - Edges seen while busy are ignored; the edge register still tracks, so a level held high through completion does not retrigger.
- States: IDLE -> CONV -> LOAD -> SEND -> (next byte: LOAD | finished: DONE) -> IDLE.
- CONV:
  - Exactly 32 cycles of double-dabble into 10 BCD digits (40 bits).
  - Each step adds 3 to any nibble ≥5, then shifts left 1.
- LOAD selects the next byte:
  - Digits are sent MSD first, with leading zeros suppressed.
  - The first digit sent is the highest-index nonzero digit, or digit 0 if the value is 0.
  - ASCII code = 0x30 + digit.
  - After the last digit: 0x0D, then 0x0A.
- SEND frame:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Frame = 10*CLKS_PER_BIT cycles.
  - Consecutive bytes are back-to-back: the next start bit begins the cycle after the previous stop bit ends, and LOAD is absorbed so no extra idle cycle appears on tx.
- Latency: tx falls (first start bit) exactly 34 clk edges after the edge that samples the trigger.
- Total busy time: 34 + (digits+2)*10*CLKS_PER_BIT cycles.
- DONE:
  - `done`=1 for one cycle, `busy`=0 that same cycle, return to IDLE.
  - A new trigger is accepted the following cycle.
- Width rules: the bit counter must hold 0..9 and the baud counter must hold CLKS_PER_BIT-1; the max value 4294967295 needs all 10 digits.
- `result` may change freely after capture with no effect on the transmission.

Test Plan:
- `result`=233168, one pulse on `result_valid`, CLKS_PER_BIT=4 -> tx bytes 0x32,0x33,0x33,0x31,0x36,0x38,0x0D,0x0A; start bit at 34 cycles after trigger; busy for 34+320 cycles; single done pulse.
- `result`=0 -> bytes 0x30,0x0D,0x0A only; `result`=1000 -> 0x31,0x30,0x30,0x30,0x0D,0x0A (interior zeros kept).
- `result`=32'hFFFFFFFF -> "4294967295" then CR LF; 12 frames with no idle gap between stop and next start.
- `result_valid` held high for 5000 cycles -> exactly one transmission; a second low->high pulse afterwards -> second transmission.
- Assert rst_n=0 mid-data-bit of byte 3 -> tx=1 and busy=0 without waiting for a clock edge; after release with `result_valid` low, tx stays 1 indefinitely.
- `result` changed to 7 during CONV and during SEND -> printed value is still the captured one (233168).
